// File: rtl/fp_result_checker.sv
// fp_result_checker: on-chip result scoreboard for the FP controller datapath.
// Golden words are queued in a FIFO and compared against each controller result.
// Each result is binned as exact, near or far (split by the sign of res-exp), or fail.
// Optional macro CHECKER_FIRST_FAIL_LOG_EN adds a first-fail capture (ff_* outputs).
module fp_result_checker #(
    parameter int          DATA_LEN   = 64,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [63:0] TOL_NEAR   = 64'd2,
    parameter logic [63:0] TOL_FAR    = 64'd1_000_000_000_000,
    parameter int          CNT_LEN    = 16
) (
    input  logic                clk,
    input  logic                srstn,
    input  logic                start,
    input  logic [CNT_LEN-1:0]  n_tests,
    input  logic                exp_valid,
    input  logic [DATA_LEN-1:0] exp_data,
    output logic                exp_ready,
    input  logic                res_valid,
    input  logic [DATA_LEN-1:0] res_data,
    output logic [CNT_LEN-1:0]  pass_cnt,
    output logic [CNT_LEN-1:0]  near_hi_cnt,
    output logic [CNT_LEN-1:0]  near_lo_cnt,
    output logic [CNT_LEN-1:0]  far_hi_cnt,
    output logic [CNT_LEN-1:0]  far_lo_cnt,
    output logic [CNT_LEN-1:0]  fail_cnt,
    output logic                fail_pulse,
    output logic                underflow_err,
    output logic                done
`ifdef CHECKER_FIRST_FAIL_LOG_EN
    ,
    output logic                ff_valid,
    output logic [CNT_LEN-1:0]  ff_idx,
    output logic [DATA_LEN-1:0] ff_exp,
    output logic [DATA_LEN-1:0] ff_res
`endif
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    // Magnitude compare width wide enough for both |d| and the 64-bit tolerances.
    localparam int CMP_W = ((DATA_LEN > 64) ? DATA_LEN : 64) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {
        CLS_PASS, CLS_NEAR_HI, CLS_NEAR_LO, CLS_FAR_HI, CLS_FAR_LO, CLS_FAIL
    } cls_t;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_LEN-1:0] sat_inc(input logic [CNT_LEN-1:0] c);
        return (&c) ? c : c + CNT_LEN'(1);
    endfunction

    // Bin res against exp using a DATA_LEN+1 bit difference so 0/all-ones never wrap.
    function automatic cls_t classify(input logic [DATA_LEN-1:0] res,
                                      input logic [DATA_LEN-1:0] exp);
        logic signed [DATA_LEN:0] d;
        logic signed [DATA_LEN:0] nd;
        logic [CMP_W-1:0]         mag;
        d   = $signed({1'b0, res}) - $signed({1'b0, exp});
        nd  = -d;
        mag = CMP_W'(d[DATA_LEN] ? nd[DATA_LEN-1:0] : d[DATA_LEN-1:0]);
        if (mag == '0)
            return CLS_PASS;
        else if (mag <= CMP_W'(TOL_NEAR))
            return d[DATA_LEN] ? CLS_NEAR_LO : CLS_NEAR_HI;
        else if (mag <= CMP_W'(TOL_FAR))
            return d[DATA_LEN] ? CLS_FAR_LO : CLS_FAR_HI;
        else
            return CLS_FAIL;
    endfunction

    state_t              state, state_next;
    logic [AW:0]         wr_ptr, rd_ptr;
    logic [AW-1:0]       wr_slot;
    logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
    logic                full, empty, push, pop, underflow_set;
    logic [DATA_LEN-1:0] head_p0;
    cls_t                cls_p0, cls_p1;
    logic                vld_p1;
    logic [CNT_LEN-1:0]  checked, n_tests_q;
`ifdef CHECKER_FIRST_FAIL_LOG_EN
    logic [DATA_LEN-1:0] exp_p1, res_p1;
`endif

    assign empty         = (wr_ptr == rd_ptr);
    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign exp_ready     = !full;
    assign push          = exp_valid && exp_ready;
    assign pop           = (state == RUN) && res_valid && !empty && !start;
    assign underflow_set = (state == RUN) && res_valid && empty && !start;
    // A push coinciding with start lands in slot 0 of the freshly cleared queue.
    assign wr_slot       = start ? '0 : wr_ptr[AW-1:0];
    assign head_p0       = mem[rd_ptr[AW-1:0]];
    assign cls_p0        = classify(res_data, head_p0);

    // Golden queue storage (data only, no reset).
    always_ff @(posedge clk) begin
        if (push) mem[wr_slot] <= exp_data;
    end

    // Queue pointers; start empties the queue, a same-cycle push is kept.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (start) begin
            rd_ptr <= '0;
            wr_ptr <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // ---- stage p0 -> p1: register the classification of the popped result ----
    always_ff @(posedge clk) begin
        if (pop) begin
            cls_p1 <= cls_p0;
`ifdef CHECKER_FIRST_FAIL_LOG_EN
            exp_p1 <= head_p0;
            res_p1 <= res_data;
`endif
        end
    end

    // ---- stage p1 -> outputs: counters, fail pulse, sticky flags ----
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            vld_p1        <= 1'b0;
            checked       <= '0;
            n_tests_q     <= '0;
            pass_cnt      <= '0;
            near_hi_cnt   <= '0;
            near_lo_cnt   <= '0;
            far_hi_cnt    <= '0;
            far_lo_cnt    <= '0;
            fail_cnt      <= '0;
            fail_pulse    <= 1'b0;
            underflow_err <= 1'b0;
        end else if (start) begin
            vld_p1        <= 1'b0;
            checked       <= '0;
            n_tests_q     <= n_tests;
            pass_cnt      <= '0;
            near_hi_cnt   <= '0;
            near_lo_cnt   <= '0;
            far_hi_cnt    <= '0;
            far_lo_cnt    <= '0;
            fail_cnt      <= '0;
            fail_pulse    <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            vld_p1     <= pop;
            fail_pulse <= 1'b0;
            if (underflow_set) underflow_err <= 1'b1;
            if (vld_p1) begin
                checked <= sat_inc(checked);
                unique case (cls_p1)
                    CLS_PASS:    pass_cnt    <= sat_inc(pass_cnt);
                    CLS_NEAR_HI: near_hi_cnt <= sat_inc(near_hi_cnt);
                    CLS_NEAR_LO: near_lo_cnt <= sat_inc(near_lo_cnt);
                    CLS_FAR_HI:  far_hi_cnt  <= sat_inc(far_hi_cnt);
                    CLS_FAR_LO:  far_lo_cnt  <= sat_inc(far_lo_cnt);
                    default: begin
                        fail_cnt   <= sat_inc(fail_cnt);
                        fail_pulse <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef CHECKER_FIRST_FAIL_LOG_EN
    // First-fail capture: 1-based index and the offending pair, never overwritten.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            ff_valid <= 1'b0;
            ff_idx   <= '0;
            ff_exp   <= '0;
            ff_res   <= '0;
        end else if (start) begin
            ff_valid <= 1'b0;
            ff_idx   <= '0;
            ff_exp   <= '0;
            ff_res   <= '0;
        end else if (vld_p1 && (cls_p1 == CLS_FAIL) && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_idx   <= sat_inc(checked);
            ff_exp   <= exp_p1;
            ff_res   <= res_p1;
        end
    end
`endif

    // Run state register.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and done; DONE is entered once every expected result is counted.
    always_comb begin
        state_next = state;
        done       = (state == DONE);
        if (start) begin
            state_next = RUN;
        end else begin
            unique case (state)
                IDLE:    state_next = IDLE;
                RUN:     if (checked == n_tests_q) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_result_checker.sv
// Directed testbench for fp_result_checker (default parameters).
module tb_fp_result_checker;

    localparam logic [63:0] E    = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] T12  = 64'd1_000_000_000_000;
    localparam logic [63:0] TOP  = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        srstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] n_tests = '0;
    logic        exp_valid = 1'b0;
    logic [63:0] exp_data = '0;
    logic        exp_ready;
    logic        res_valid = 1'b0;
    logic [63:0] res_data = '0;
    logic [15:0] pass_cnt, near_hi_cnt, near_lo_cnt, far_hi_cnt, far_lo_cnt, fail_cnt;
    logic        fail_pulse, underflow_err, done;
`ifdef CHECKER_FIRST_FAIL_LOG_EN
    logic        ff_valid;
    logic [15:0] ff_idx;
    logic [63:0] ff_exp, ff_res;
`endif

    int total = 0;
    int bad   = 0;

    fp_result_checker dut (
        .clk(clk), .srstn(srstn), .start(start), .n_tests(n_tests),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
        .res_valid(res_valid), .res_data(res_data),
        .pass_cnt(pass_cnt), .near_hi_cnt(near_hi_cnt), .near_lo_cnt(near_lo_cnt),
        .far_hi_cnt(far_hi_cnt), .far_lo_cnt(far_lo_cnt), .fail_cnt(fail_cnt),
        .fail_pulse(fail_pulse), .underflow_err(underflow_err), .done(done)
`ifdef CHECKER_FIRST_FAIL_LOG_EN
        , .ff_valid(ff_valid), .ff_idx(ff_idx), .ff_exp(ff_exp), .ff_res(ff_res)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        n_tests = n;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [63:0] v);
        exp_valid = 1'b1;
        exp_data = v;
        step();
        exp_valid = 1'b0;
    endtask

    task automatic result(input logic [63:0] v);
        res_valid = 1'b1;
        res_data = v;
        step();
        res_valid = 1'b0;
    endtask

    task automatic both(input logic [63:0] e, input logic [63:0] r);
        exp_valid = 1'b1;
        exp_data = e;
        res_valid = 1'b1;
        res_data = r;
        step();
        exp_valid = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pass"}, 64'(pass_cnt), 64'd0);
        check({tag, "_nearhi"}, 64'(near_hi_cnt), 64'd0);
        check({tag, "_nearlo"}, 64'(near_lo_cnt), 64'd0);
        check({tag, "_farhi"}, 64'(far_hi_cnt), 64'd0);
        check({tag, "_farlo"}, 64'(far_lo_cnt), 64'd0);
        check({tag, "_fail"}, 64'(fail_cnt), 64'd0);
        check({tag, "_pulse"}, 64'(fail_pulse), 64'd0);
        check({tag, "_uflow"}, 64'(underflow_err), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ready"}, 64'(exp_ready), 64'd1);
`ifdef CHECKER_FIRST_FAIL_LOG_EN
        check({tag, "_ffv"}, 64'(ff_valid), 64'd0);
        check({tag, "_ffidx"}, 64'(ff_idx), 64'd0);
`endif
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check_reset_state("rst");
        srstn = 1'b1;
        step();

        // Four exact matches
        do_start(16'd4);
        for (int i = 0; i < 4; i++) push(64'h1111_0000 + 64'(i));
        for (int i = 0; i < 4; i++) result(64'h1111_0000 + 64'(i));
        step();
        check("exact_pass", 64'(pass_cnt), 64'd4);
        check("exact_fail", 64'(fail_cnt), 64'd0);
        check("exact_near", 64'(near_hi_cnt + near_lo_cnt), 64'd0);
        check("exact_done_early", 64'(done), 64'd0);
        step();
        check("exact_done", 64'(done), 64'd1);

        // Near / far / fail bins around 1.0
        do_start(16'd5);
        for (int i = 0; i < 5; i++) push(E);
        result(E + 64'd2);
        result(E - 64'd1);
        result(E + 64'd3);
        result(E + T12);
        check("bins_pulse_low", 64'(fail_pulse), 64'd0);
        result(E + T12 + 64'd1);
        step();
        check("bins_nearhi", 64'(near_hi_cnt), 64'd1);
        check("bins_nearlo", 64'(near_lo_cnt), 64'd1);
        check("bins_farhi", 64'(far_hi_cnt), 64'd2);
        check("bins_fail", 64'(fail_cnt), 64'd1);
        check("bins_pass", 64'(pass_cnt), 64'd0);
        check("bins_pulse", 64'(fail_pulse), 64'd1);
        step();
        check("bins_pulse_one_cycle", 64'(fail_pulse), 64'd0);
        check("bins_done", 64'(done), 64'd1);

        // Boundary words: no wrap at 0 / all-ones
        do_start(16'd3);
        push(64'd0);
        push(ONES);
        push(E);
        result(ONES);
        result(ONES - 64'd2);
        result(E - 64'd100);
        step();
        check("bnd_fail", 64'(fail_cnt), 64'd1);
        check("bnd_nearlo", 64'(near_lo_cnt), 64'd1);
        check("bnd_farlo", 64'(far_lo_cnt), 64'd1);
        check("bnd_nearhi", 64'(near_hi_cnt), 64'd0);
        check("bnd_farhi_cleared", 64'(far_hi_cnt), 64'd0);

        // Fill, full blocking, push+pop, pointer wrap
        do_start(16'd20);
        for (int i = 0; i < 16; i++) push(64'd100 + 64'(i));
        check("full_ready", 64'(exp_ready), 64'd0);
        both(64'd999, 64'd100);
        check("full_popped_ready", 64'(exp_ready), 64'd1);
        both(64'd116, 64'd101);
        check("pp15_ready", 64'(exp_ready), 64'd1);
        for (int i = 2; i <= 16; i++) result(64'd100 + 64'(i));
        step();
        check("wrap_pass", 64'(pass_cnt), 64'd17);
        check("wrap_fail", 64'(fail_cnt), 64'd0);
        push(64'd117);
        both(64'd118, 64'd117);
        result(64'd118);
        step();
        check("pp1_pass", 64'(pass_cnt), 64'd19);
        check("pp1_fail", 64'(fail_cnt), 64'd0);

        // Underflow
        result(64'd5);
        step();
        check("uflow_flag", 64'(underflow_err), 64'd1);
        check("uflow_pass", 64'(pass_cnt), 64'd19);
        check("uflow_fail", 64'(fail_cnt), 64'd0);
        check("uflow_done", 64'(done), 64'd0);
        do_start(16'd0);
        check("start_clr_uflow", 64'(underflow_err), 64'd0);
        check("start_clr_pass", 64'(pass_cnt), 64'd0);
        check("n0_not_done", 64'(done), 64'd0);
        step();
        check("n0_done", 64'(done), 64'd1);

        // Async reset mid-run
        do_start(16'd8);
        for (int i = 0; i < 8; i++) push(64'h1000 + 64'(i));
        for (int i = 0; i < 3; i++) result(64'h1000 + 64'(i));
        step();
        check("mid_pass", 64'(pass_cnt), 64'd3);
        #2 srstn = 1'b0;
        #1;
        check_reset_state("midrst");
        #2 srstn = 1'b1;
        step();

        // Run with fails at idx 5 and 7
        do_start(16'd8);
        for (int i = 0; i < 8; i++) push(64'h2000 + 64'(i));
        for (int i = 0; i < 8; i++) begin
            if (i == 4 || i == 6) result((64'h2000 + 64'(i)) ^ TOP);
            else result(64'h2000 + 64'(i));
        end
        step();
        check("ff_run_pass", 64'(pass_cnt), 64'd6);
        check("ff_run_fail", 64'(fail_cnt), 64'd2);
`ifdef CHECKER_FIRST_FAIL_LOG_EN
        check("ff_valid", 64'(ff_valid), 64'd1);
        check("ff_idx", 64'(ff_idx), 64'd5);
        check("ff_exp", ff_exp, 64'h2004);
        check("ff_res", ff_res, 64'h2004 ^ TOP);
`endif
        step();
        check("ff_run_done", 64'(done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
